// File: rtl/i2c_reg_sequencer_if.sv
// Handshake bundle between the register sequencer, its table ROM, the I2C
// frame sender and top-level control.
interface i2c_reg_sequencer_if #(
    parameter int IDX_W = 4
);
    logic             start;
    logic [IDX_W-1:0] tbl_addr;
    logic [15:0]      tbl_data;
    logic             tx_req;
    logic [23:0]      tx_data;
    logic             tx_done;
    logic             tx_nack;
    logic             busy;
    logic             done;
    logic             error;
    logic [IDX_W-1:0] err_idx;

    modport master (
        input  start, tbl_data, tx_done, tx_nack,
        output tbl_addr, tx_req, tx_data, busy, done, error, err_idx
    );

    modport slave (
        output start, tbl_data, tx_done, tx_nack,
        input  tbl_addr, tx_req, tx_data, busy, done, error, err_idx
    );
endinterface

// File: rtl/i2c_reg_sequencer.sv
// Power-up register programmer: walks a ROM table and hands each entry, prefixed
// with the device write address, to an I2C frame sender, retrying failed frames.
module i2c_reg_sequencer #(
    parameter int         N_REGS     = 11,
    parameter logic [6:0] DEV_ADDR   = 7'h1A,
    parameter int         GAP_CYCLES = 8,
    parameter int         MAX_RETRY  = 3,
    parameter int         TIMEOUT    = 4096,
    parameter int         IDX_W      = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
    input logic i_clk,
    input logic i_rst,
    i2c_reg_sequencer_if.master bus
);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_REGS - 1);
    localparam logic [RW-1:0]    RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [TW-1:0]    TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0]    GAP_LAST  = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, SEND, WAIT, GAP, DONE, ERR
    } state_t;

    state_t           state, state_n, pend, pend_n;
    logic [IDX_W-1:0] idx, idx_n, addr_q, addr_n, eidx_q, eidx_n;
    logic [RW-1:0]    retry, retry_n;
    logic [TW-1:0]    to_cnt, to_n;
    logic [GW-1:0]    gap_cnt, gap_n;
    logic [23:0]      data_q, data_n;
    logic             ok, fail;

    // A done arriving on the last timeout cycle still counts as an answer.
    assign ok   = bus.tx_done && !bus.tx_nack;
    assign fail = bus.tx_done ? bus.tx_nack : (to_cnt == TO_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            pend    <= IDLE;
            idx     <= '0;
            retry   <= '0;
            to_cnt  <= '0;
            gap_cnt <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            eidx_q  <= '0;
        end else begin
            state   <= state_n;
            pend    <= pend_n;
            idx     <= idx_n;
            retry   <= retry_n;
            to_cnt  <= to_n;
            gap_cnt <= gap_n;
            addr_q  <= addr_n;
            data_q  <= data_n;
            eidx_q  <= eidx_n;
        end
    end

    always_comb begin
        state_n = state;
        pend_n  = pend;
        idx_n   = idx;
        retry_n = retry;
        to_n    = to_cnt;
        gap_n   = gap_cnt;
        addr_n  = addr_q;
        data_n  = data_q;
        eidx_n  = eidx_q;
        unique case (state)
            IDLE, DONE, ERR: begin
                if (bus.start) begin
                    idx_n   = '0;
                    retry_n = '0;
                    state_n = FETCH;
                end
            end
            FETCH: begin
                addr_n  = idx;
                state_n = LOAD;
            end
            LOAD: begin
                data_n  = {DEV_ADDR, 1'b0, bus.tbl_data};
                state_n = SEND;
            end
            SEND: begin
                to_n    = '0;
                state_n = WAIT;
            end
            WAIT: begin
                if (ok) begin
                    retry_n = '0;
                    if (idx == IDX_LAST) begin
                        state_n = DONE;
                    end else begin
                        idx_n   = idx + IDX_W'(1);
                        pend_n  = FETCH;
                        gap_n   = '0;
                        state_n = GAP;
                    end
                end else if (fail) begin
                    if (retry < RETRY_MAX) begin
                        retry_n = retry + RW'(1);
                        pend_n  = SEND;
                        gap_n   = '0;
                        state_n = GAP;
                    end else begin
                        eidx_n  = idx;
                        state_n = ERR;
                    end
                end else begin
                    to_n = to_cnt + TW'(1);
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) state_n = pend;
                else                     gap_n   = gap_cnt + GW'(1);
            end
        endcase
    end

    assign bus.tbl_addr = addr_q;
    assign bus.tx_data  = data_q;
    assign bus.err_idx  = eidx_q;
    assign bus.tx_req   = (state == SEND);
    assign bus.done     = (state == DONE);
    assign bus.error    = (state == ERR);
    assign bus.busy     = !(state == IDLE || state == DONE || state == ERR);
endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Randomised bench for i2c_reg_sequencer: a transaction-level model predicts the
// request stream, per-request timing and final status for each run.
module tb_i2c_reg_sequencer;
    localparam int N      = 3;
    localparam int GAP    = 8;
    localparam int MAXR   = 3;
    localparam int TOUT   = 16;
    localparam logic [6:0] DEV = 7'h1A;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2c_reg_sequencer_if #(.IDX_W(2)) bus ();

    i2c_reg_sequencer #(
        .N_REGS(N), .DEV_ADDR(DEV), .GAP_CYCLES(GAP),
        .MAX_RETRY(MAXR), .TIMEOUT(TOUT), .IDX_W(2)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus)
    );

    logic [15:0] rom [0:3];
    assign bus.tbl_data = rom[bus.tbl_addr];

    int errors = 0;
    int checks = 0;

    // Per-entry plan: number of failing attempts before an ACK, and whether
    // failures are silent (timeout) rather than NACKs.
    int plan_fails [N];
    bit plan_silent [N];

    logic [23:0] exp_data [$];
    int          exp_resp [$];   // 0 ack, 1 nack, 2 no answer
    int          exp_lat  [$];
    bit          exp_err;
    int          exp_eidx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic build_model();
        bit stop = 0;
        exp_data.delete();
        exp_resp.delete();
        exp_lat.delete();
        exp_err  = 0;
        exp_eidx = 0;
        for (int e = 0; e < N && !stop; e++) begin
            for (int a = 0; a <= MAXR; a++) begin
                bit f = (a < plan_fails[e]);
                exp_data.push_back({DEV, 1'b0, rom[e]});
                exp_resp.push_back(f ? (plan_silent[e] ? 2 : 1) : 0);
                exp_lat.push_back($urandom_range(1, TOUT - 1));
                if (!f) break;
                if (a == MAXR) begin
                    exp_err  = 1;
                    exp_eidx = e;
                    stop     = 1;
                end
            end
        end
    endtask

    task automatic run_seq(input string name);
        int c = 0, next_req = 3, done_at = -1, spur_at = -1, nseen = 0;
        int busy_start_at;
        bit pend_nack = 0, fin = 0;
        build_model();
        busy_start_at = ($urandom_range(0, 1) == 1) ? 5 : -1;
        @(negedge clk);
        bus.start = 1'b1;
        while (!fin && c < 3000) begin
            @(negedge clk);
            c++;
            bus.start   = (c == busy_start_at);
            bus.tx_done = 1'b0;
            bus.tx_nack = 1'b0;
            if (c == done_at) begin
                bus.tx_done = 1'b1;
                bus.tx_nack = pend_nack;
            end else if (c == spur_at) begin
                bus.tx_done = 1'b1;
                bus.tx_nack = 1'($urandom_range(0, 1));
            end
            if (bus.tx_req) begin
                check({name, ".req_time"}, c, next_req);
                if (nseen < exp_data.size()) begin
                    check({name, ".tx_data"}, bus.tx_data, exp_data[nseen]);
                    if (exp_resp[nseen] == 2) begin
                        done_at  = -1;
                        spur_at  = -1;
                        next_req = c + TOUT + GAP + 1;
                    end else begin
                        done_at   = c + exp_lat[nseen];
                        pend_nack = (exp_resp[nseen] == 1);
                        next_req  = done_at + GAP + ((exp_resp[nseen] == 0) ? 3 : 1);
                        spur_at   = ($urandom_range(0, 1) == 1) ? done_at + 2 : -1;
                    end
                end
                nseen++;
            end
            if (bus.done || bus.error) fin = 1;
        end
        bus.tx_done = 1'b0;
        bus.start   = 1'b0;
        check({name, ".finished"}, 32'(fin), 1);
        check({name, ".req_count"}, nseen, exp_data.size());
        check({name, ".done"}, bus.done, !exp_err);
        check({name, ".error"}, bus.error, exp_err);
        check({name, ".busy"}, bus.busy, 0);
        if (exp_err) check({name, ".err_idx"}, bus.err_idx, exp_eidx);
        repeat (4) @(negedge clk);
        check({name, ".hold_done"}, bus.done, !exp_err);
        check({name, ".hold_req"}, bus.tx_req, 0);
    endtask

    task automatic set_plan(input int f0, input int f1, input int f2, input bit silent);
        plan_fails[0] = f0; plan_fails[1] = f1; plan_fails[2] = f2;
        for (int i = 0; i < N; i++) plan_silent[i] = silent;
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, ".busy"},     bus.busy, 0);
        check({name, ".tx_req"},   bus.tx_req, 0);
        check({name, ".done"},     bus.done, 0);
        check({name, ".error"},    bus.error, 0);
        check({name, ".tbl_addr"}, bus.tbl_addr, 0);
        check({name, ".tx_data"},  bus.tx_data, 0);
        check({name, ".err_idx"},  bus.err_idx, 0);
    endtask

    task automatic run_reset_mid();
        int n = 0, ack_at = -1;
        @(negedge clk);
        bus.start = 1'b1;
        for (int k = 1; k < 200 && n < 2; k++) begin
            @(negedge clk);
            bus.start   = 1'b0;
            bus.tx_done = (k == ack_at);
            bus.tx_nack = 1'b0;
            if (bus.tx_req) begin
                n++;
                if (n == 1) ack_at = k + 2;
            end
        end
        bus.tx_done = 1'b0;
        check("rst_mid.reached_entry1", n, 2);
        check("rst_mid.tbl_addr_before", bus.tbl_addr, 1);
        @(negedge clk);
        check("rst_mid.busy_before", bus.busy, 1);
        #2 rst = 1'b1;
        #1 check_outputs_zero("rst_mid");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.tx_done = 1'b0;
        bus.tx_nack = 1'b0;
        rom[0] = 16'h0817; rom[1] = 16'h0A00; rom[2] = 16'h1201; rom[3] = 16'h0000;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("idle");

        set_plan(0, 0, 0, 0); run_seq("all_ack");
        set_plan(0, 2, 0, 0); run_seq("retry_e1");
        set_plan(0, 0, 4, 0); run_seq("nack_e2");
        set_plan(4, 0, 0, 1); run_seq("timeout_e0");
        set_plan(0, 0, 0, 0); run_seq("rerun");
        run_reset_mid();
        set_plan(0, 0, 0, 0); run_seq("after_rst");

        for (int r = 0; r < 12; r++) begin
            for (int e = 0; e < N; e++) begin
                int v = $urandom_range(0, 9);
                rom[e]         = 16'($urandom);
                plan_fails[e]  = (v < 6) ? 0 : v - 5;
                plan_silent[e] = ($urandom_range(0, 3) == 0);
            end
            run_seq($sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
